mem_port_arbiter: RTL and testbench

- Sequences one single-port unified memory shared by two requesters: instruction fetch (IF) and the data-memory stage (DM, driven by the decoded MEM_CS/MEM_RD controls of LW/SW).
- Per-access FSM with request/grant/valid handshake and variable memory latency (mem_ready).
- Data has priority, with a bounded-starvation guarantee for fetch.
- Sits between the pipeline's fetch/memory stages and the memory macro.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, data first with bounded fetch starvation.
// Optional timeout: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;
  localparam int SW = MAX_DM_STREAK > 0 ? $clog2(MAX_DM_STREAK + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(MAX_DM_STREAK);
  localparam bit FAIR = MAX_DM_STREAK > 0;
  state_t state_q;
  logic [SW-1:0] streak_q;
  logic if_gnt_q, dm_gnt_q, if_valid_q, dm_valid_q, mem_cs_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic idle, if_win, dm_win, tmo, done;
  always_comb begin
    idle   = state_q == IDLE;
    if_win = idle & if_req & (~dm_req | (FAIR & (streak_q == SMAX)));
    dm_win = idle & dm_req & ~if_win;
    done   = ~idle & (mem_ready | tmo);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_gnt_q   <= if_win;
      dm_gnt_q   <= dm_win;
      if_valid_q <= done & (state_q == IF_ACC);
      dm_valid_q <= done & (state_q == DM_ACC);
      if (if_win | dm_win) begin
        state_q    <= dm_win ? DM_ACC : IF_ACC;
        mem_cs_q   <= 1'b1;
        mem_we_q   <= dm_win & dm_we;
        mem_addr_q <= dm_win ? dm_addr : if_addr;
        if (dm_win) mem_wdata_q <= dm_wdata;
      end else if (done) begin
        state_q  <= IDLE;
        mem_cs_q <= 1'b0;
        mem_we_q <= 1'b0;
      end
      if (done & (state_q == IF_ACC)) if_rdata_q <= tmo ? '0 : mem_rdata;
      if (done & (state_q == DM_ACC) & (tmo | ~mem_we_q)) dm_rdata_q <= tmo ? '0 : mem_rdata;
      // streak only counts DM wins that actually bypassed a waiting fetch
      if (if_win | (idle & ~if_req)) streak_q <= '0;
      else if (dm_win & (streak_q != SMAX)) streak_q <= streak_q + 1'b1;
    end
  end
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt_q;
  logic err_q;
  assign tmo = ~idle & ~mem_ready & (tcnt_q == TLAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= (idle | done) ? '0 : tcnt_q + 1'b1;
      err_q  <= err_q | tmo;
    end
  end
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  assign busy      = ~idle;
  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter; a second instance runs with MAX_DM_STREAK=0.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic if_gnt, if_valid, dm_gnt, dm_valid, mem_cs, mem_we, busy, err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic s_if_gnt, s_if_valid, s_dm_gnt, s_dm_valid, s_mem_cs, s_mem_we, s_busy, s_err;
  logic [31:0] s_if_rdata, s_dm_rdata, s_mem_addr, s_mem_wdata;
  int n_cmp = 0, n_err = 0;
  logic [31:0] last_if = '0, last_dm = '0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.TIMEOUT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .err(err));
  mem_port_arbiter #(.MAX_DM_STREAK(0), .TIMEOUT(8)) u_s0 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(s_if_gnt),
    .if_valid(s_if_valid), .if_rdata(s_if_rdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(s_dm_gnt), .dm_valid(s_dm_valid),
    .dm_rdata(s_dm_rdata), .mem_cs(s_mem_cs), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(s_busy), .err(s_err));
  typedef struct {
    logic dm; logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    int waits; logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic chk_s(input string n, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %s expected %s", n, act, exp);
    end
  endtask
  task automatic do_acc(input vec_t v);
    logic [1:0] g;
    g = v.dm ? 2'b01 : 2'b10;
    mem_rdata = v.rdata;
    mem_ready = 0;
    if (v.dm) begin
      dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    tick();
    if (v.dm && v.we) chk("gnt_wdata", mem_wdata, v.wdata);
    if_req = 0; dm_req = 0;
    if_addr = ~v.addr; dm_addr = ~v.addr; dm_wdata = ~v.wdata;
    for (int w = 0; w <= v.waits; w++) begin
      chk("acc_ctl", {if_gnt, dm_gnt, mem_cs, mem_we, busy, if_valid, dm_valid},
          {(w == 0) ? g : 2'b00, 1'b1, v.dm & v.we, 1'b1, 2'b00});
      chk("acc_addr", mem_addr, v.addr);
      if (w == v.waits) mem_ready = 1;
      tick();
    end
    mem_ready = 0;
    chk("done_ctl", {if_valid, dm_valid, if_gnt, dm_gnt, busy, mem_cs, mem_we}, {~v.dm, v.dm, 5'b0});
    chk("rdata", v.dm ? dm_rdata : if_rdata, v.exp);
    chk("other_rdata", v.dm ? if_rdata : dm_rdata, v.dm ? last_if : last_dm);
    if (v.dm) last_dm = v.exp; else last_if = v.exp;
    tick();
    chk("pulse_end", {if_valid, dm_valid, busy, mem_cs}, 4'b0);
    chk("addr_held", mem_addr, v.addr);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    string got, gs0;
    tbl[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h1111_2222, 0, 32'h1111_2222};
    tbl[1] = '{1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h5555_5555, 3, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h1001_0004, 32'h0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D};
    tbl[3] = '{1'b1, 1'b1, 32'h1001_0008, 32'h1234_5678, 32'h0BAD_F00D, 0, 32'hCAFE_F00D};
    tbl[4] = '{1'b0, 1'b0, 32'h0040_0004, 32'h0, 32'hA5A5_A5A5, 2, 32'hA5A5_A5A5};
    tbl[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF};
    #12;
    chk("rst_ctl", {if_gnt, if_valid, dm_gnt, dm_valid, mem_cs, mem_we, busy, err}, 8'b0);
    chk("rst_addr", mem_addr | mem_wdata | if_rdata | dm_rdata, 32'h0);
    tick();
    rst_n = 1;
    tick();
    chk("idle_ctl", {if_gnt, dm_gnt, busy, mem_cs}, 4'b0);
    for (int i = 0; i < 6; i++) do_acc(tbl[i]);
    // both requesters hold their requests; memory answers every access at once
    got = ""; gs0 = "";
    mem_rdata = 32'h77; mem_ready = 1; if_req = 1; dm_req = 1; dm_we = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dm_gnt) got = {got, "D"};
      if (if_gnt) got = {got, "I"};
      if (s_dm_gnt) gs0 = {gs0, "D"};
      if (s_if_gnt) gs0 = {gs0, "I"};
    end
    if_req = 0; dm_req = 0; mem_ready = 0;
    tick();
    chk_s("streak4_order", got, "DDDDIDDDDI");
    chk_s("streak0_order", gs0, "DDDDDDDDDD");
    chk("streak_idle", {busy, s_busy}, 2'b0);
    last_if = 32'h77; last_dm = 32'h77;
    // asynchronous reset in the middle of a DM write
    dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0010; dm_wdata = 32'h0F0F_0F0F;
    tick();
    chk("rst_mid_gnt", {dm_gnt, busy, mem_cs, mem_we}, 4'b1111);
    dm_req = 0;
    tick();
    #2 rst_n = 0;
    #1;
    chk("rst_mid_ctl", {if_gnt, if_valid, dm_gnt, dm_valid, mem_cs, mem_we, busy, err}, 8'b0);
    chk("rst_mid_data", {mem_addr | mem_wdata | if_rdata | dm_rdata}, 32'h0);
    mem_ready = 1;
    tick();
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_no_valid", {dm_valid, if_valid, busy}, 3'b0);
    end
    last_if = '0; last_dm = '0;
    do_acc(tbl[2]);
    // memory never answers
    mem_rdata = 32'h9999_9999; mem_ready = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    tick();
    chk("stall_gnt", {dm_gnt, s_dm_gnt}, 2'b11);
    dm_req = 0;
    repeat (7) tick();
    chk("stall_7", {dm_valid, busy, err}, 3'b010);
`ifdef MEM_ARB_TIMEOUT_EN
    tick();
    chk("tmo_fire", {dm_valid, busy, err, s_dm_valid, s_err}, 5'b10111);
    chk("tmo_rdata", dm_rdata, 32'h0);
    repeat (3) tick();
    chk("tmo_sticky", {dm_valid, busy, err}, 3'b001);
`else
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("stall_hold", {dm_valid, busy, err, s_busy}, 4'b0101);
    end
    chk("stall_rdata", dm_rdata, 32'hCAFE_F00D);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
